rcntlr_bank_arbiter: RTL and testbench
======================================

// Module: rcntlr_bank_arbiter
// PURPOSE
//  Shares the single-port register_bank (wr/address/data_in/data_out) between two requesters.
//  - m0 is the host; m1 is the SPI-side controller.
//  - Sequences each access (write, or multi-cycle read with capture) and arbitrates round-robin.
//  - After reset, optionally sweeps the whole bank to a known value before serving requests.
//  - Sits directly in front of register_bank; chip_out is untouched.
// PARAMETERS
//  ADDR_W    `ADDR_W (5)  bank address width; bank depth = 2**ADDR_W
//  DATA_W    `DATA_W (8)  register width
//  INIT_EN   1            1: sweep-write INIT_VAL to every address after reset; 0: skip the sweep
//  INIT_VAL  0            DATA_W-bit value written during the sweep
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset, asynchronous, active-high
//  m0_req/m1_req  in   1       request; held with wr/addr/wdata stable until ack
//  m0_wr/m1_wr    in   1       1 = write, 0 = read
//  m0_addr/m1_addr in  ADDR_W  target register
//  m0_wdata/m1_wdata in DATA_W write data
//  m0_ack/m1_ack  out  1       one-cycle completion pulse
//  m0_rdata/m1_rdata out DATA_W read data; valid in ack cycle, held until next read ack to that port
//  bank_wr        out  1       to register_bank wr
//  bank_address   out  ADDR_W  to register_bank address
//  bank_data_in   out  DATA_W  to register_bank data_in
//  bank_data_out  in   DATA_W  from register_bank data_out
//  init_done      out  1       1 once the sweep is complete (or INIT_EN=0); stays 1 until reset
//  busy           out  1       1 when state != IDLE
// BEHAVIOUR
//  Reset (async, immediate): state=INIT (INIT_EN=1) or IDLE (INIT_EN=0).
//   - Zeroed: all acks, rdata, bank_wr, bank_address, bank_data_in, init_done, sweep counter.
//   - rr_last=1, so m0 wins the first tie.
//  FSM states: INIT, IDLE, WRITE, RD_ADDR, RD_WAIT, RD_ACK. All bank_* outputs are registered.
//  INIT:
//   - bank_wr=1, bank_data_in=INIT_VAL, bank_address=cnt; cnt runs 0..2**ADDR_W-1, one per cycle.
//   - After the last address: IDLE, with init_done=1 from the first IDLE cycle.
//   - Requests are not sampled; no acks are issued.
//  INIT_EN=0: init_done=1 from the first cycle after rst deasserts.
//  IDLE: sample the request lines each edge.
//   - One requester: grant it.
//   - Both: grant the port != rr_last. rr_last updates on grant.
//   - Latch the winner's wr/addr/wdata.
//  Write path: IDLE -> WRITE.
//   - bank_wr=1 for exactly one cycle, carrying the latched address and data.
//   - mX_ack=1 in that same cycle; next state IDLE.
//  Read path: IDLE -> RD_ADDR -> RD_WAIT -> RD_ACK -> IDLE.
//   - bank_address is held from RD_ADDR through RD_ACK; bank_wr=0 throughout.
//   - rdata register loads bank_data_out on the edge ending RD_WAIT.
//   - mX_ack=1 in RD_ACK.
//  Latency (req seen at edge k): write ack in cycle k+1; read ack in cycle k+3.
//  Throughput: one IDLE cycle separates transactions. A req still high in the cycle after its ack
//   is a new transaction.
//  Fairness: with m0 and m1 both held high, grants alternate m0, m1, m0, ... No starvation.
//  Only the granted port is acked. The losing request stays pending, unlatched, until granted.
//  Addresses wrap naturally within ADDR_W. The sweep counter is ADDR_W+1 bits so it terminates.
//  Reset mid-transaction: the access is aborted, no ack is issued, and the sweep restarts from 0.
//   - A bank write in flight on the reset edge is not guaranteed.
// STRUCTURE
//  rcntlr_defines.v (shared header, package role): state encodings RC_INIT..RC_RD_ACK,
//   RC_STATE_W, ADDR_W/DATA_W defaults.
//  Sub-module rcntlr_rr_arb: 2-way round-robin grant from (req0, req1, rr_last, en).
//   Combinational grant, registered rr_last.
//  Top: FSM, sweep counter, request latches, per-port rdata registers.
// TESTING
//  1. Reset then idle, INIT_EN=1, INIT_VAL=8'hA5:
//     - bank_wr high for 32 consecutive cycles, bank_address 0..31, init_done rises on cycle 33.
//     - Read-back of addresses 0, 17, 31 returns 8'hA5.
//  2. m0 writes 8'h3C to 5'd7:
//     - bank_wr=1 with addr 7 / data 3C in cycle k+1, m0_ack the same cycle.
//     - m0 read of 5'd7 then gives m0_ack at k+3 with m0_rdata=8'h3C.
//  3. m0 and m1 both held high; m0 writes 8'h11 to addr 1, m1 writes 8'h22 to addr 2:
//     - Acks alternate m0, m1, m0, m1. Bank addrs 1 and 2 hold 11 and 22.
//  4. Request asserted during INIT: no ack until init_done=1, then served with normal latency.
//  5. rst pulsed during RD_WAIT of an m1 read:
//     - Outputs are zero immediately, m1_ack never pulses.
//     - The sweep restarts from address 0.
//  6. m1 writes 8'hFF to addr 5'd31, then reads it: m1_rdata=8'hFF. Addr 0 is unchanged.

Source files
------------

// File: rtl/rcntlr_bank_arbiter_pkg.sv
// Shared types and defaults for the register-bank arbiter.
package rcntlr_bank_arbiter_pkg;

  localparam int RC_ADDR_W  = 5;
  localparam int RC_DATA_W  = 8;
  localparam int RC_STATE_W = 3;

  typedef enum logic [RC_STATE_W-1:0] {
    RC_INIT    = 3'd0,
    RC_IDLE    = 3'd1,
    RC_WRITE   = 3'd2,
    RC_RD_ADDR = 3'd3,
    RC_RD_WAIT = 3'd4,
    RC_RD_ACK  = 3'd5
  } rc_state_e;

endpackage

// File: rtl/rcntlr_bank_arbiter_rr_arb.sv
// Two-way round-robin grant. The grant is combinational; the memory of
// who won last is registered and only moves when a grant is issued.
module rcntlr_rr_arb
  import rcntlr_bank_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic en,
  output logic gnt0,
  output logic gnt1
);

  logic rr_last_q;
  logic rr_last_d;

  // Grant the sole requester, or on a tie the port that did not win last.
  always_comb begin
    gnt0      = en & req0 & (~req1 | rr_last_q);
    gnt1      = en & req1 & (~req0 | ~rr_last_q);
    rr_last_d = rr_last_q;
    if (gnt0) begin
      rr_last_d = 1'b0;
    end else if (gnt1) begin
      rr_last_d = 1'b1;
    end
  end

  // rr_last resets to 1 so m0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/rcntlr_bank_arbiter.sv
// Shares a single-port register bank between the host (m0) and the SPI-side
// controller (m1). Optionally sweeps the bank to INIT_VAL after reset.
//
// state      | meaning
// RC_INIT    | sweep-writing INIT_VAL to every address
// RC_IDLE    | sampling requests, granting one
// RC_WRITE   | single bank write cycle, ack to the granted port
// RC_RD_ADDR | read address presented to the bank
// RC_RD_WAIT | bank data settling; captured on the edge leaving this state
// RC_RD_ACK  | read data valid, ack to the granted port
module rcntlr_bank_arbiter
  import rcntlr_bank_arbiter_pkg::*;
#(
  parameter int                ADDR_W   = RC_ADDR_W,
  parameter int                DATA_W   = RC_DATA_W,
  parameter bit                INIT_EN  = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              bank_wr,
  output logic [ADDR_W-1:0] bank_address,
  output logic [DATA_W-1:0] bank_data_in,
  input  logic [DATA_W-1:0] bank_data_out,
  output logic              init_done,
  output logic              busy
);

  // One past the last address: the extra counter bit lets the sweep end.
  localparam logic [ADDR_W:0] CNT_END = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  rc_state_e         state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              bank_wr_q, bank_wr_d;
  logic [ADDR_W-1:0] bank_address_q, bank_address_d;
  logic [DATA_W-1:0] bank_data_in_q, bank_data_in_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              init_done_q, init_done_d;
  logic              gnt0, gnt1;

  rcntlr_rr_arb u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (m0_req),
    .req1 (m1_req),
    .en   (state_q == RC_IDLE),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  // Next-state and registered-output decode for the access sequencer.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sel_d          = sel_q;
    bank_wr_d      = 1'b0;
    bank_address_d = bank_address_q;
    bank_data_in_d = bank_data_in_q;
    m0_ack_d       = 1'b0;
    m1_ack_d       = 1'b0;
    m0_rdata_d     = m0_rdata_q;
    m1_rdata_d     = m1_rdata_q;
    init_done_d    = init_done_q;
    case (state_q)
      RC_INIT: begin
        if (cnt_q == CNT_END) begin
          state_d     = RC_IDLE;
          init_done_d = 1'b1;
        end else begin
          bank_wr_d      = 1'b1;
          bank_address_d = cnt_q[ADDR_W-1:0];
          bank_data_in_d = INIT_VAL;
          cnt_d          = cnt_q + CNT_ONE;
        end
      end
      RC_IDLE: begin
        init_done_d = 1'b1;
        if (gnt0 || gnt1) begin
          sel_d          = gnt1;
          bank_address_d = gnt1 ? m1_addr : m0_addr;
          if (gnt1 ? m1_wr : m0_wr) begin
            state_d        = RC_WRITE;
            bank_wr_d      = 1'b1;
            bank_data_in_d = gnt1 ? m1_wdata : m0_wdata;
            m0_ack_d       = gnt0;
            m1_ack_d       = gnt1;
          end else begin
            state_d = RC_RD_ADDR;
          end
        end
      end
      RC_WRITE:   state_d = RC_IDLE;
      RC_RD_ADDR: state_d = RC_RD_WAIT;
      RC_RD_WAIT: begin
        state_d = RC_RD_ACK;
        if (sel_q) begin
          m1_rdata_d = bank_data_out;
          m1_ack_d   = 1'b1;
        end else begin
          m0_rdata_d = bank_data_out;
          m0_ack_d   = 1'b1;
        end
      end
      RC_RD_ACK:  state_d = RC_IDLE;
      default:    state_d = RC_IDLE;
    endcase
  end

  // State and output registers; reset aborts any access and restarts the sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (INIT_EN) begin
        state_q <= RC_INIT;
      end else begin
        state_q <= RC_IDLE;
      end
      cnt_q          <= '0;
      sel_q          <= 1'b0;
      bank_wr_q      <= 1'b0;
      bank_address_q <= '0;
      bank_data_in_q <= '0;
      m0_ack_q       <= 1'b0;
      m1_ack_q       <= 1'b0;
      m0_rdata_q     <= '0;
      m1_rdata_q     <= '0;
      init_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sel_q          <= sel_d;
      bank_wr_q      <= bank_wr_d;
      bank_address_q <= bank_address_d;
      bank_data_in_q <= bank_data_in_d;
      m0_ack_q       <= m0_ack_d;
      m1_ack_q       <= m1_ack_d;
      m0_rdata_q     <= m0_rdata_d;
      m1_rdata_q     <= m1_rdata_d;
      init_done_q    <= init_done_d;
    end
  end

  assign bank_wr      = bank_wr_q;
  assign bank_address = bank_address_q;
  assign bank_data_in = bank_data_in_q;
  assign m0_ack       = m0_ack_q;
  assign m1_ack       = m1_ack_q;
  assign m0_rdata     = m0_rdata_q;
  assign m1_rdata     = m1_rdata_q;
  assign init_done    = init_done_q;
  assign busy         = (state_q != RC_IDLE);

endmodule

// File: tb/tb_rcntlr_bank_arbiter.sv
// Bench for the bank arbiter: a register-bank model, per-port drivers that
// push expectations into queues, and a monitor that checks every ack.
module tb_rcntlr_bank_arbiter;

  localparam int   AW    = 5;
  localparam int   DW    = 8;
  localparam int   DEPTH = 1 << AW;
  localparam logic [DW-1:0] IVAL = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_ack, m1_ack, bank_wr, init_done, busy;
  logic [DW-1:0] m0_rdata, m1_rdata, bank_data_in, bank_data_out;
  logic [AW-1:0] bank_address;

  rcntlr_bank_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_EN(1'b1), .INIT_VAL(IVAL)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bank_wr(bank_wr), .bank_address(bank_address), .bank_data_in(bank_data_in),
    .bank_data_out(bank_data_out), .init_done(init_done), .busy(busy)
  );

  always #5 clk = ~clk;

  // register_bank model: synchronous write, combinational read
  logic [DW-1:0] bank_mem [DEPTH];
  always @(posedge clk) if (bank_wr) bank_mem[bank_address] <= bank_data_in;
  assign bank_data_out = bank_mem[bank_address];

  typedef struct { bit wr; logic [DW-1:0] data; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int last_port = 1;
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Issue one transaction on port p and wait for its ack; lat counts edges.
  task automatic txn(input int p, input bit wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, output int lat);
    exp_t e;
    e.wr = wr;
    if (wr) ref_mem[a] = d;
    e.data = ref_mem[a];
    if (p == 0) begin
      q0.push_back(e);
      m0_wr = wr; m0_addr = a; m0_wdata = d; m0_req = 1'b1;
    end else begin
      q1.push_back(e);
      m1_wr = wr; m1_addr = a; m1_wdata = d; m1_req = 1'b1;
    end
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if ((p == 0) ? m0_ack : m1_ack) break;
      if (lat > 100) begin
        chk($sformatf("ack_timeout_p%0d", p), 64'(lat), 0);
        break;
      end
    end
    if (p == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  // Directed transaction from an idle DUT, with latency checked.
  task automatic dtxn(input int p, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int lat;
    @(posedge clk); #1;
    txn(p, wr, a, d, lat);
    chk(wr ? "write_latency" : "read_latency", 64'(lat), wr ? 64'd1 : 64'd3);
  endtask

  task automatic apply_reset();
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0;
    @(posedge clk); #1;
    chk("reset_outputs", {bank_wr, bank_address, bank_data_in, m0_ack, m1_ack,
                          m0_rdata, m1_rdata, init_done}, 64'd0);
    chk("reset_busy", busy, 1);
    rst = 1'b0;
    last_port = 1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = IVAL;
  endtask

  task automatic sweep_check();
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      chk($sformatf("sweep_cycle_%0d", i), {bank_wr, bank_address, bank_data_in, init_done},
          {1'b1, 5'(i), IVAL, 1'b0});
    end
    @(posedge clk); #1;
    chk("sweep_end", {bank_wr, init_done, busy}, 3'b010);
  endtask

  // Monitor: every ack must match the oldest pending transaction of its port.
  initial forever begin
    exp_t e;
    @(posedge clk); #1;
    if (m0_ack || m1_ack) begin
      chk("single_ack", m0_ack & m1_ack, 0);
      chk("ack_after_init", init_done, 1);
    end
    if (m0_ack) begin
      chk("m0_ack_pending", q0.size() > 0, 1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        if (!e.wr) chk("m0_rdata", m0_rdata, e.data);
      end
      last_port = 0;
    end
    if (m1_ack) begin
      chk("m1_ack_pending", q1.size() > 0, 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        if (!e.wr) chk("m1_rdata", m1_rdata, e.data);
      end
      last_port = 1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic rand_driver(input int p);
    int lat;
    for (int n = 0; n < 30; n++) begin
      int gap;
      logic [AW-1:0] a;
      gap = $urandom_range(0, 3);
      repeat (gap) begin @(posedge clk); #1; end
      a = 5'(($urandom_range(0, 15) * 2) + p);
      txn(p, 1'($urandom_range(0, 1)), a, 8'($urandom), lat);
    end
  endtask

  initial begin
    int lat;
    // 1: reset, sweep, read-back
    apply_reset();
    sweep_check();
    dtxn(0, 1'b0, 5'd0, '0);
    dtxn(0, 1'b0, 5'd17, '0);
    dtxn(0, 1'b0, 5'd31, '0);

    // 2: m0 write then read of address 7
    dtxn(0, 1'b1, 5'd7, 8'h3C);
    chk("write_bank_bus", {bank_wr, bank_address, bank_data_in}, {1'b1, 5'd7, 8'h3C});
    @(posedge clk); #1;
    chk("write_one_cycle", bank_wr, 0);
    dtxn(0, 1'b0, 5'd7, '0);

    // 6: m1 write/read at top address, address 0 untouched
    dtxn(1, 1'b1, 5'd31, 8'hFF);
    dtxn(1, 1'b0, 5'd31, '0);
    dtxn(1, 1'b0, 5'd0, '0);

    // 3: both held high, grants must alternate starting away from last winner
    begin
      exp_t e;
      int prev, n, cyc;
      @(posedge clk); #1;
      e.wr = 1'b1;
      ref_mem[1] = 8'h11; ref_mem[2] = 8'h22;
      e.data = 8'h11; q0.push_back(e); q0.push_back(e);
      e.data = 8'h22; q1.push_back(e); q1.push_back(e);
      m0_wr = 1'b1; m0_addr = 5'd1; m0_wdata = 8'h11;
      m1_wr = 1'b1; m1_addr = 5'd2; m1_wdata = 8'h22;
      prev = last_port;
      m0_req = 1'b1; m1_req = 1'b1;
      n = 0; cyc = 0;
      while (n < 4 && cyc < 60) begin
        @(posedge clk); #1;
        cyc++;
        if (m0_ack || m1_ack) begin
          chk($sformatf("rr_grant_%0d", n), m1_ack ? 1 : 0, 64'(1 - prev));
          prev = m1_ack ? 1 : 0;
          n++;
        end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      chk("rr_ack_count", 64'(n), 4);
      @(posedge clk); #1;
      chk("rr_queues_drained", 64'(q0.size() + q1.size()), 0);
      dtxn(0, 1'b0, 5'd1, '0);
      dtxn(1, 1'b0, 5'd2, '0);
    end

    // 5: reset during RD_WAIT of an m1 read
    @(posedge clk); #1;
    m1_wr = 1'b0; m1_addr = 5'd3; m1_req = 1'b1;
    @(posedge clk); #1;
    chk("rd_addr_busy", {busy, bank_address}, {1'b1, 5'd3});
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("midreset_outputs", {bank_wr, bank_address, bank_data_in, m0_ack, m1_ack,
                             m0_rdata, m1_rdata, init_done}, 64'd0);
    m1_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_port = 1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = IVAL;
    sweep_check();

    // 4: request raised during the sweep is served once init_done rises
    apply_reset();
    repeat (5) begin @(posedge clk); #1; end
    txn(0, 1'b1, 5'd9, 8'h5A, lat);
    chk("init_blocked_latency", 64'(lat), 64'((DEPTH + 2) - 5));
    dtxn(0, 1'b0, 5'd9, '0);

    // random traffic: m0 owns even addresses, m1 odd ones
    fork
      rand_driver(0);
      rand_driver(1);
    join
    repeat (5) begin @(posedge clk); #1; end
    chk("final_queues_empty", 64'(q0.size() + q1.size()), 0);
    chk("final_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
